// File: rtl/hemaia_clk_rst_pkg.sv
// Shared types for the clock/reset observers: monitor FSM encoding and lock counter sizing.
// No logic; imported by the ratio monitor and its helpers.
package hemaia_clk_rst_pkg;

  typedef enum logic [1:0] {
    MonIdle,
    MonArm,
    MonMeasure,
    MonLocked
  } mon_state_e;

  // Wide enough for lock thresholds up to 15.
  localparam int unsigned LockCntWidth = 4;

endpackage

// File: rtl/hemaia_edge_sampler.sv
// Brings an asynchronous level into clk_i through a 2-FF synchronizer and derives edge pulses.
// Latency: a 0->1 sampled at edge k gives rise_o in the cycle after edge k+1; no backpressure.
module hemaia_edge_sampler (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic sig_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else if (clear_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign s_o    = sync2_q;
  assign rise_o = sync2_q & ~prev_q;
  assign fall_o = ~sync2_q & prev_q;

endmodule

// File: rtl/hemaia_clock_ratio_monitor.sv
// Measures period and high time of a divided clock sampled as data; reports lock, mismatch, stuck.
// Results register on the rise that closes each period; purely observing, never stalls anything.
module hemaia_clock_ratio_monitor
  import hemaia_clk_rst_pkg::*;
#(
  parameter int unsigned CountWidth = 8,
  parameter int unsigned LockCount  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  clear_i,
  input  logic                  sig_i,
  input  logic [CountWidth-1:0] expected_i,
  output logic [CountWidth-1:0] period_o,
  output logic [CountWidth-1:0] high_o,
  output logic                  meas_valid_o,
  output logic                  locked_o,
  output logic                  mismatch_o,
  output logic                  stuck_o
);

  localparam logic [CountWidth-1:0]   CntMax     = '1;
  localparam logic [CountWidth-1:0]   CntOne     = CountWidth'(1);
  localparam logic [LockCntWidth-1:0] LockOne    = LockCntWidth'(1);
  localparam logic [LockCntWidth-1:0] LockTarget = LockCntWidth'(LockCount);

  function automatic logic [CountWidth-1:0] sat_inc(input logic [CountWidth-1:0] v);
    return (v == CntMax) ? v : v + CntOne;
  endfunction

  logic s, rise, fall;

  hemaia_edge_sampler i_edge_sampler (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .sig_i   (sig_i),
    .s_o     (s),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  mon_state_e                state_q, state_d;
  logic [CountWidth-1:0]     cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [CountWidth-1:0]     period_q, period_d, high_q, high_d;
  logic [LockCntWidth-1:0]   lock_q, lock_d;
  logic                      hfrozen_q, hfrozen_d;
  logic                      valid_q, valid_d, stuck_q, stuck_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    hfrozen_d = hfrozen_q;
    period_d  = period_q;
    high_d    = high_q;
    lock_d    = lock_q;
    valid_d   = 1'b0;
    stuck_d   = stuck_q;

    if (clear_i) begin
      state_d   = MonIdle;
      cnt_d     = '0;
      hcnt_d    = '0;
      hfrozen_d = 1'b0;
      period_d  = '0;
      high_d    = '0;
      lock_d    = '0;
      stuck_d   = 1'b0;
    end else if (!enable_i) begin
      state_d   = MonIdle;
      cnt_d     = '0;
      hcnt_d    = '0;
      hfrozen_d = 1'b0;
      lock_d    = '0;
    end else begin
      unique case (state_q)
        MonIdle: state_d = MonArm;
        MonArm: begin
          if (rise) begin
            cnt_d     = CntOne;
            hcnt_d    = CntOne;
            hfrozen_d = 1'b0;
            stuck_d   = 1'b0;
            state_d   = MonMeasure;
          end
        end
        MonMeasure, MonLocked: begin
          if (rise) begin
            // A rise coinciding with saturation still reports the saturated count.
            period_d  = cnt_q;
            high_d    = hcnt_q;
            valid_d   = 1'b1;
            cnt_d     = CntOne;
            hcnt_d    = CntOne;
            hfrozen_d = 1'b0;
            if (cnt_q == period_q) begin
              lock_d = (lock_q < LockTarget) ? lock_q + LockOne : lock_q;
            end else begin
              lock_d = LockOne;
            end
            state_d = (lock_d >= LockTarget) ? MonLocked : MonMeasure;
          end else if (cnt_q == CntMax) begin
            stuck_d = 1'b1;
            cnt_d   = '0;
            hcnt_d  = '0;
            lock_d  = '0;
            state_d = MonArm;
          end else begin
            cnt_d = sat_inc(cnt_q);
            if (fall) hfrozen_d = 1'b1;
            if (s && !hfrozen_q) hcnt_d = sat_inc(hcnt_q);
          end
        end
        default: state_d = MonIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= MonIdle;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      hfrozen_q <= 1'b0;
      period_q  <= '0;
      high_q    <= '0;
      lock_q    <= '0;
      valid_q   <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      hfrozen_q <= hfrozen_d;
      period_q  <= period_d;
      high_q    <= high_d;
      lock_q    <= lock_d;
      valid_q   <= valid_d;
      stuck_q   <= stuck_d;
    end
  end

  assign period_o     = period_q;
  assign high_o       = high_q;
  assign meas_valid_o = valid_q;
  assign locked_o     = (state_q == MonLocked);
  assign stuck_o      = stuck_q;
  assign mismatch_o   = locked_o && (expected_i != '0) && (period_q != expected_i);

endmodule

// File: tb/tb_hemaia_clock_ratio_monitor.sv
// Directed bench for the clock ratio monitor with a timestamp-based reference model.
module tb_hemaia_clock_ratio_monitor;

  localparam int CW    = 8;
  localparam int LOCKN = 4;
  localparam int MAXV  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          clr = 1'b0;
  logic          sig = 1'b0;
  logic [CW-1:0] expct = '0;
  logic [CW-1:0] period, high;
  logic          mv, locked, mism, stuck;

  always #5 clk = ~clk;

  hemaia_clock_ratio_monitor #(
    .CountWidth (CW),
    .LockCount  (LOCKN)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (en),
    .clear_i      (clr),
    .sig_i        (sig),
    .expected_i   (expct),
    .period_o     (period),
    .high_o       (high),
    .meas_valid_o (mv),
    .locked_o     (locked),
    .mismatch_o   (mism),
    .stuck_o      (stuck)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 armed, 2 measuring. Periods come from rise timestamps.
  int m_mode, m_last, m_hi, m_streak, m_period, m_high, cyc;
  bit m_s1, m_s2, m_prev, m_mv, m_locked, m_stuck;
  int mv_seen = 0;
  int lock_at = -1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_last = 0; m_hi = 0; m_streak = 0; m_period = 0; m_high = 0;
    m_s1 = 0; m_s2 = 0; m_prev = 0; m_mv = 0; m_locked = 0; m_stuck = 0;
  endtask

  task automatic model_step();
    bit rise, s;
    int elapsed;
    rise = m_s2 && !m_prev;
    s    = m_s2;
    if (clr) begin
      model_reset();
    end else begin
      m_prev = m_s2; m_s2 = m_s1; m_s1 = sig;
      m_mv = 0;
      if (!en) begin
        m_mode = 0; m_locked = 0; m_streak = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (rise) begin
          m_mode = 2; m_last = cyc; m_hi = 1; m_stuck = 0;
        end
      end else begin
        elapsed = cyc - m_last;
        if (rise) begin
          m_mv     = 1;
          m_high   = (m_hi > MAXV) ? MAXV : m_hi;
          m_streak = (elapsed == m_period) ? ((m_streak + 1 > LOCKN) ? LOCKN : m_streak + 1) : 1;
          m_period = elapsed;
          m_locked = (m_streak >= LOCKN);
          m_last   = cyc;
          m_hi     = 1;
        end else if (elapsed >= MAXV) begin
          m_stuck = 1; m_locked = 0; m_mode = 1; m_streak = 0;
        end else if (s) begin
          m_hi++;
        end
      end
    end
    cyc++;
  endtask

  task automatic compare_all();
    chk("period_o", int'(period), m_period);
    chk("high_o", int'(high), m_high);
    chk("meas_valid_o", int'(mv), int'(m_mv));
    chk("locked_o", int'(locked), int'(m_locked));
    chk("stuck_o", int'(stuck), int'(m_stuck));
    chk("mismatch_o", int'(mism), int'(m_locked && expct != 0 && m_period != int'(expct)));
  endtask

  // One clock: compare and advance the model at the falling edge, then move inputs after the rise.
  task automatic tick();
    @(negedge clk);
    if (!rst_n) model_reset();
    compare_all();
    if (mv) mv_seen++;
    if (locked && lock_at < 0) lock_at = mv_seen;
    if (rst_n) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      sig = 1'b1;
      repeat (hi) tick();
      sig = 1'b0;
      repeat (lo) tick();
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, int'({period, high, mv, locked, mism, stuck}), 0);
  endtask

  initial begin
    model_reset();
    cyc = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk_zero("reset_state");

    // Period 4, 2 high: lock on the 4th equal measurement.
    en = 1'b1;
    repeat (3) tick();
    expct = 8'd4;
    mv_seen = 0; lock_at = -1;
    wave(2, 2, 8);
    chk("p4_period", int'(period), 4);
    chk("p4_high", int'(high), 2);
    chk("p4_locked", int'(locked), 1);
    chk("p4_mismatch", int'(mism), 0);
    chk("p4_lock_on_4th", lock_at, 4);
    chk("p4_meas_count", mv_seen, 7);

    // Period 5, 3 high, against an expected 4.
    wave(3, 2, 6);
    chk("p5_period", int'(period), 5);
    chk("p5_high", int'(high), 3);
    chk("p5_locked", int'(locked), 1);
    chk("p5_mismatch", int'(mism), 1);

    // Lock at 6, then move to 8: unlock then relock.
    expct = 8'd6;
    wave(3, 3, 6);
    chk("p6_locked", int'(locked), 1);
    chk("p6_period", int'(period), 6);
    expct = 8'd8;
    wave(4, 4, 2);
    chk("p8_unlock", int'(locked), 0);
    chk("p8_first_period", int'(period), 8);
    chk("p8_high", int'(high), 4);
    wave(4, 4, 3);
    chk("p8_relock", int'(locked), 1);
    chk("p8_mismatch", int'(mism), 0);

    // Input held low: stuck after the counter saturates.
    sig = 1'b0;
    repeat (240) tick();
    chk("stuck_not_yet", int'(stuck), 0);
    chk("locked_before_stuck", int'(locked), 1);
    repeat (60) tick();
    chk("stuck_set", int'(stuck), 1);
    chk("stuck_unlock", int'(locked), 0);
    chk("stuck_period_kept", int'(period), 8);
    mv_seen = 0;
    wave(4, 4, 2);
    chk("stuck_cleared", int'(stuck), 0);
    chk("stuck_rearm_meas", mv_seen, 1);
    chk("stuck_period", int'(period), 8);

    // Synchronous clear mid-measurement.
    wave(4, 4, 3);
    sig = 1'b1;
    repeat (4) tick();
    sig = 1'b0;
    repeat (2) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_zero("clear_outputs");
    repeat (3) tick();
    mv_seen = 0;
    wave(4, 4, 2);
    chk("clear_rearm_meas", mv_seen, 1);
    chk("clear_period", int'(period), 8);

    // Asynchronous reset mid-measurement.
    sig = 1'b1;
    repeat (2) tick();
    sig = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk_zero("reset_immediate");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    mv_seen = 0;
    wave(4, 4, 2);
    chk("reset_rearm_meas", mv_seen, 1);
    chk("reset_period", int'(period), 8);

    // Disable while locked, then re-enable.
    wave(4, 4, 4);
    chk("en_locked", int'(locked), 1);
    expct = 8'd5;
    #1;
    chk("mismatch_comb", int'(mism), 1);
    expct = 8'd0;
    #1;
    chk("mismatch_disabled", int'(mism), 0);
    en = 1'b0;
    tick();
    chk("dis_unlock", int'(locked), 0);
    chk("dis_period_kept", int'(period), 8);
    chk("dis_high_kept", int'(high), 4);
    repeat (5) tick();
    en = 1'b1;
    mv_seen = 0;
    wave(4, 4, 1);
    chk("reen_no_meas", mv_seen, 0);
    wave(4, 4, 1);
    chk("reen_second_rise", mv_seen, 1);
    chk("reen_period", int'(period), 8);

    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
